// File: rtl/modular_adder_arbiter_if.sv
// ---------------------------------------------------------------------------
// modular_adder_arbiter_if
// Bundles the request, result and control signals between two requesters
// (plus the flush/busy controls) and the shared modular adder arbiter.
//
// Handshake: a request transfers on a rising clk edge where reqX_valid and
// reqX_ready are both 1. While reqX_valid=1 and reqX_ready=0 the requester
// keeps reqX_a/b/tag stable and may not drop valid. reqX_ready may depend on
// reqX_valid. Results carry no backpressure: resX_c/resX_tag must be taken
// on the cycle resX_valid=1.
//
// Signals:
//   flush                     drop all in-flight operations, no grant
//   reqX_valid/ready          request handshake for requester X (0/1)
//   reqX_a, reqX_b            30-bit operands, both < Q
//   reqX_tag                  caller tag returned with the result
//   resX_valid/c/tag          result for requester X
//   busy                      any operation in flight or granted
//
// Modports: master = requester/controller side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface modular_adder_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             flush;
  logic             req0_valid;
  logic             req0_ready;
  logic [29:0]      req0_a;
  logic [29:0]      req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic [29:0]      req1_a;
  logic [29:0]      req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic             res0_valid;
  logic [29:0]      res0_c;
  logic [TAG_W-1:0] res0_tag;
  logic             res1_valid;
  logic [29:0]      res1_c;
  logic [TAG_W-1:0] res1_tag;
  logic             busy;

  modport master (
    output flush,
    output req0_valid, req0_a, req0_b, req0_tag,
    output req1_valid, req1_a, req1_b, req1_tag,
    input  req0_ready, req1_ready,
    input  res0_valid, res0_c, res0_tag,
    input  res1_valid, res1_c, res1_tag,
    input  busy
  );

  modport slave (
    input  flush,
    input  req0_valid, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_tag,
    output req0_ready, req1_ready,
    output res0_valid, res0_c, res0_tag,
    output res1_valid, res1_c, res1_tag,
    output busy
  );
endinterface

// File: rtl/modular_adder_arbiter.sv
// ---------------------------------------------------------------------------
// modular_adder_arbiter
// Shares one 2-cycle pipelined modular adder c = (a+b) mod Q between two
// requesters with round-robin arbitration. A 2-stage tag pipeline runs in
// lock-step with the adder so each result returns to its requester with the
// caller tag, exactly two edges after the transfer.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (acts as flush, and makes
//                requester 0 win the next contention)
//   bus          modular_adder_arbiter_if.slave (requests, results,
//                flush, busy)
//   grant_cnt0/1 (only with ARB_STATS_EN) saturating 32-bit transfer
//                counts per requester, cleared by reset only
//
// Build option: define ARB_STATS_EN to add the grant counters.
//
// Contains modular_adder, the shared adder itself; its datapath registers
// are not reset, stale sums are masked by the cleared pipeline valids.
// ---------------------------------------------------------------------------

// modular_adder: c = (a+b) mod Q, two register stages, a/b must be < Q.
//   clk  clock
//   a,b  operands (< Q)
//   c    result, valid two edges after a/b are presented
module modular_adder #(
  parameter logic [29:0] Q = 30'd1073479681
) (
  input  logic        clk,
  input  logic [29:0] a,
  input  logic [29:0] b,
  output logic [29:0] c
);
  logic [30:0] sum_q;

  always_ff @(posedge clk) begin
    sum_q <= {1'b0, a} + {1'b0, b};
  end

  // When sum >= Q the true difference is < Q and fits in 30 bits, so the
  // subtraction can be done modulo 2^30 on the low bits.
  always_ff @(posedge clk) begin
    if (sum_q >= {1'b0, Q}) c <= sum_q[29:0] - Q;
    else                    c <= sum_q[29:0];
  end
endmodule

module modular_adder_arbiter #(
  parameter logic [29:0] Q     = 30'd1073479681,
  parameter int          TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  modular_adder_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]            grant_cnt0,
  output logic [31:0]            grant_cnt1
`endif
);
  logic             grant0;
  logic             grant1;
  logic             any_grant;
  logic             last_grant;   // requester that won the most recent grant
  logic [29:0]      add_a;
  logic [29:0]      add_b;
  logic [29:0]      add_c;

  logic             p1_valid;
  logic             p1_id;
  logic [TAG_W-1:0] p1_tag;
  logic             p2_valid;
  logic             p2_id;
  logic [TAG_W-1:0] p2_tag;

  // Round-robin arbitration. Under contention the requester that did not
  // win last time is granted; a lone requester is always granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && !bus.flush) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign any_grant      = grant0 | grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Operand mux; zeros keep the adder inputs quiet when nobody is granted.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (grant0) begin
      add_a = bus.req0_a;
      add_b = bus.req0_b;
    end else if (grant1) begin
      add_a = bus.req1_a;
      add_b = bus.req1_b;
    end
  end

  modular_adder #(.Q(Q)) u_adder (
    .clk (clk),
    .a   (add_a),
    .b   (add_b),
    .c   (add_c)
  );

  // Tag pipeline, aligned with the adder's two register stages. Flush
  // blocks the grant (so stage 1 loads 0) and kills stage 1 before it
  // reaches stage 2; whatever is already in stage 2 is shown this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_valid   <= 1'b0;
      p1_id      <= 1'b0;
      p1_tag     <= '0;
      p2_valid   <= 1'b0;
      p2_id      <= 1'b0;
      p2_tag     <= '0;
      last_grant <= 1'b1;
    end else begin
      p1_valid <= any_grant;
      p2_valid <= p1_valid & ~bus.flush;
      if (any_grant) begin
        p1_id      <= grant1;
        p1_tag     <= grant1 ? bus.req1_tag : bus.req0_tag;
        last_grant <= grant1;
      end
      p2_id  <= p1_id;
      p2_tag <= p1_tag;
    end
  end

  assign bus.res0_valid = p2_valid & ~p2_id;
  assign bus.res1_valid = p2_valid &  p2_id;
  assign bus.res0_c     = add_c;
  assign bus.res1_c     = add_c;
  assign bus.res0_tag   = p2_tag;
  assign bus.res1_tag   = p2_tag;
  assign bus.busy       = p1_valid | p2_valid | any_grant;

`ifdef ARB_STATS_EN
  // A grant always coincides with a transfer, since ready implies valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant0 && grant_cnt0 != 32'hFFFF_FFFF) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (grant1 && grant_cnt1 != 32'hFFFF_FFFF) grant_cnt1 <= grant_cnt1 + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_modular_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_modular_adder_arbiter
// Self-checking bench for modular_adder_arbiter: directed scenarios with
// literal expectations, then randomized traffic with random flush/reset.
// A behavioural model (queue of expected results keyed by due cycle) is
// compared against the DUT on every falling edge.
// ---------------------------------------------------------------------------
module tb_modular_adder_arbiter;
  localparam logic [29:0] Q     = 30'd1073479681;
  localparam int          TAG_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  modular_adder_arbiter_if #(.TAG_W(TAG_W)) bus ();

`ifdef ARB_STATS_EN
  logic [31:0] grant_cnt0;
  logic [31:0] grant_cnt1;
`endif

  modular_adder_arbiter #(.Q(Q), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  typedef struct packed {
    logic [31:0]      due;   // cycle in which the result must be visible
    logic             id;
    logic [29:0]      c;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t        exp_q[$];
  logic        m_last = 1'b1;
  logic [31:0] cyc = 0;
  bit          live = 0;
  logic [31:0] m_cnt0 = 0;
  logic [31:0] m_cnt1 = 0;
  bit          xfer0 = 0;
  bit          xfer1 = 0;

  function automatic logic [29:0] mod_add(input logic [29:0] a, input logic [29:0] b);
    longint unsigned s;
    s = (longint'(a) + longint'(b)) % longint'(Q);
    return s[29:0];
  endfunction

  logic        eg0, eg1, ev0, ev1, pend;
  logic [29:0] ec0, ec1;
  logic [TAG_W-1:0] et0, et1;
  ent_t        keep_q[$];
  ent_t        ne;

  always @(negedge clk) begin
    xfer0 = bus.req0_valid & bus.req0_ready;
    xfer1 = bus.req1_valid & bus.req1_ready;
    if (live) begin
      // Who should win: nobody under flush/reset; a lone requester; under
      // contention the one that did not win last time.
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (rst_n && !bus.flush) begin
        if (bus.req0_valid && bus.req1_valid) begin
          if (m_last == 1'b1) eg0 = 1'b1;
          else                eg1 = 1'b1;
        end else begin
          eg0 = bus.req0_valid;
          eg1 = bus.req1_valid;
        end
      end
      check("req0_ready", bus.req0_ready, eg0);
      check("req1_ready", bus.req1_ready, eg1);

      ev0 = 0; ev1 = 0; pend = 0;
      ec0 = '0; ec1 = '0; et0 = '0; et1 = '0;
      foreach (exp_q[i]) begin
        if (exp_q[i].due >= cyc) pend = 1;
        if (exp_q[i].due == cyc) begin
          if (exp_q[i].id) begin ev1 = 1; ec1 = exp_q[i].c; et1 = exp_q[i].tag; end
          else             begin ev0 = 1; ec0 = exp_q[i].c; et0 = exp_q[i].tag; end
        end
      end
      check("res0_valid", bus.res0_valid, ev0);
      check("res1_valid", bus.res1_valid, ev1);
      if (ev0) begin
        check("res0_c", bus.res0_c, ec0);
        check("res0_tag", bus.res0_tag, et0);
      end
      if (ev1) begin
        check("res1_c", bus.res1_c, ec1);
        check("res1_tag", bus.res1_tag, et1);
      end
      check("busy", bus.busy, pend | eg0 | eg1);
`ifdef ARB_STATS_EN
      check("grant_cnt0", grant_cnt0, m_cnt0);
      check("grant_cnt1", grant_cnt1, m_cnt1);
`endif

      // Advance the model to the next edge.
      keep_q.delete();
      foreach (exp_q[i]) begin
        if (exp_q[i].due > cyc && !(bus.flush && exp_q[i].due == cyc + 1))
          keep_q.push_back(exp_q[i]);
      end
      exp_q = keep_q;
      if (!rst_n) begin
        exp_q.delete();
        m_last = 1'b1;
        m_cnt0 = 0;
        m_cnt1 = 0;
      end else if (eg0 || eg1) begin
        ne.due = cyc + 2;
        ne.id  = eg1;
        ne.c   = eg1 ? mod_add(bus.req1_a, bus.req1_b) : mod_add(bus.req0_a, bus.req0_b);
        ne.tag = eg1 ? bus.req1_tag : bus.req0_tag;
        exp_q.push_back(ne);
        m_last = eg1;
        if (eg0 && m_cnt0 != 32'hFFFF_FFFF) m_cnt0++;
        if (eg1 && m_cnt1 != 32'hFFFF_FFFF) m_cnt1++;
      end
    end else if (!rst_n) begin
      live = 1;
      exp_q.delete();
      m_last = 1'b1;
      m_cnt0 = 0;
      m_cnt1 = 0;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush      = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_tag   = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_tag   = '0;
  endtask

  task automatic drive0(input logic v, input logic [29:0] a, input logic [29:0] b, input logic [TAG_W-1:0] t);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_tag = t;
  endtask

  task automatic drive1(input logic v, input logic [29:0] a, input logic [29:0] b, input logic [TAG_W-1:0] t);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_tag = t;
  endtask

  function automatic logic [29:0] rand_op();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return Q - 30'd1;
    if (r == 1) return 30'd0;
    return 30'($urandom_range(32'(Q) - 1, 0));
  endfunction

  // One isolated operation from requester id; result checked two edges later.
  task automatic single_op(input logic id, input logic [29:0] a, input logic [29:0] b,
                           input logic [TAG_W-1:0] t, input logic [29:0] exp_c);
    if (id) drive1(1'b1, a, b, t); else drive0(1'b1, a, b, t);
    @(negedge clk);
    check("single_ready", id ? bus.req1_ready : bus.req0_ready, 1'b1);
    step();
    idle_inputs();
    step();
    @(negedge clk);
    check("single_valid", id ? bus.res1_valid : bus.res0_valid, 1'b1);
    check("single_c",     id ? bus.res1_c     : bus.res0_c,     exp_c);
    check("single_tag",   id ? bus.res1_tag   : bus.res0_tag,   t);
    check("single_other", id ? bus.res0_valid : bus.res1_valid, 1'b0);
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] exp_gnt;
    logic [TAG_W-1:0] t0, t1;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_res0_valid", bus.res0_valid, 1'b0);
    check("rst_res1_valid", bus.res1_valid, 1'b0);
    check("rst_res0_tag", bus.res0_tag, 0);
    check("rst_res1_tag", bus.res1_tag, 0);
`ifdef ARB_STATS_EN
    check("rst_cnt0", grant_cnt0, 0);
    check("rst_cnt1", grant_cnt1, 0);
`endif
    step();

    // Wrap, no wrap, zero.
    single_op(1'b0, Q - 30'd1, 30'd5, 4'd3, 30'd4);
    single_op(1'b1, 30'd100, 30'd200, 4'd7, 30'd300);
    single_op(1'b0, 30'd0, 30'd0, 4'd9, 30'd0);

    // Contention straight after reset: grants 0,1,0,1,0,1. The loser holds
    // its operands; the winner presents a fresh op with a new tag.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    t0 = 4'd0;
    t1 = 4'd8;
    drive0(1'b1, 30'd11, 30'd22, t0);
    drive1(1'b1, Q - 30'd2, 30'd7, t1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      check("contention_grant", {bus.req1_ready, bus.req0_ready}, exp_gnt);
      step();
      if (xfer0) begin t0 = t0 + 4'd1; drive0(1'b1, 30'(11 + i), 30'(22 * i), t0); end
      if (xfer1) begin t1 = t1 + 4'd1; drive1(1'b1, Q - 30'd2, 30'(7 + i), t1); end
    end
    idle_inputs();
    repeat (3) step();

    // Flush one cycle after a transfer, with a new request pending.
    drive0(1'b1, 30'd1, 30'd2, 4'd1);
    @(negedge clk);
    check("flush_first_ready", bus.req0_ready, 1'b1);
    step();
    bus.flush = 1'b1;
    drive0(1'b1, 30'd3, 30'd4, 4'd2);
    @(negedge clk);
    check("flush_no_grant", bus.req0_ready, 1'b0);
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_dropped", bus.res0_valid, 1'b0);
    check("flush_pending_granted", bus.req0_ready, 1'b1);
    step();
    idle_inputs();
    repeat (2) step();
    @(negedge clk);
    check("flush_busy_clear", bus.busy, 1'b0);
    step();

    // Reset one cycle after a transfer; contention afterwards favours 0.
    drive0(1'b1, 30'd5, 30'd6, 4'd4);
    @(negedge clk);
    check("rstmid_ready", bus.req0_ready, 1'b1);
    step();
    drive0(1'b0, 30'd0, 30'd0, 4'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive0(1'b1, 30'd8, 30'd9, 4'd5);
    drive1(1'b1, 30'd10, 30'd11, 4'd6);
    @(negedge clk);
    check("rstmid_no_result", bus.res0_valid, 1'b0);
    check("rstmid_first_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
`ifdef ARB_STATS_EN
    check("rstmid_cnt0_zero", grant_cnt0, 0);
    check("rstmid_cnt1_zero", grant_cnt1, 0);
`endif
    repeat (3) step();
    idle_inputs();
    @(negedge clk);
`ifdef ARB_STATS_EN
    check("stats_cnt0_after3", grant_cnt0, 2);
    check("stats_cnt1_after3", grant_cnt1, 1);
`endif
    repeat (3) step();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 2000; i++) begin
      bus.flush = ($urandom_range(0, 19) == 0);
      rst_n     = !($urandom_range(0, 199) == 0);
      if (!(bus.req0_valid && !xfer0)) begin
        if ($urandom_range(0, 9) < 6) drive0(1'b1, rand_op(), rand_op(), 4'($urandom));
        else                          drive0(1'b0, 30'd0, 30'd0, 4'd0);
      end
      if (!(bus.req1_valid && !xfer1)) begin
        if ($urandom_range(0, 9) < 6) drive1(1'b1, rand_op(), rand_op(), 4'($urandom));
        else                          drive1(1'b0, 30'd0, 30'd0, 4'd0);
      end
      step();
    end
    idle_inputs();
    rst_n = 1'b1;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
